// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands, result, status and PSR are registered around the shared ALU.
module alu_arbiter #(
    parameter int unsigned P_WIDTH = 16
) (
    input  logic                   I_CLK,
    input  logic                   I_RESET,
    input  logic [1:0]             I_REQ_VALID,
    output logic [1:0]             O_REQ_READY,
    input  logic [7:0]             I_REQ_OPCODE,
    input  logic [2*P_WIDTH-1:0]   I_REQ_A,
    input  logic [2*P_WIDTH-1:0]   I_REQ_B,
    output logic [1:0]             O_RSP_VALID,
    input  logic [1:0]             I_RSP_READY,
    output logic [P_WIDTH-1:0]     O_RSP_C,
    output logic [4:0]             O_RSP_STATUS,
    output logic [3:0]             O_ALU_OPCODE,
    output logic [P_WIDTH-1:0]     O_ALU_A,
    output logic [P_WIDTH-1:0]     O_ALU_B,
    input  logic [P_WIDTH-1:0]     I_ALU_C,
    input  logic [4:0]             I_ALU_STATUS,
    output logic [4:0]             O_PSR,
    output logic                   O_BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic       ptr;
    logic       owner;
    logic [1:0] grant;
    logic       sel;

    // Grant only in IDLE; on contention the pointer's side wins
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (I_REQ_VALID)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign O_REQ_READY = grant;
    assign sel         = grant[1];

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state        <= IDLE;
            ptr          <= 1'b0;
            owner        <= 1'b0;
            O_RSP_VALID  <= 2'b00;
            O_RSP_C      <= '0;
            O_RSP_STATUS <= '0;
            O_ALU_OPCODE <= '0;
            O_ALU_A      <= '0;
            O_ALU_B      <= '0;
            O_PSR        <= '0;
            O_BUSY       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner        <= sel;
                        O_ALU_OPCODE <= sel ? I_REQ_OPCODE[7:4] : I_REQ_OPCODE[3:0];
                        O_ALU_A      <= sel ? I_REQ_A[2*P_WIDTH-1:P_WIDTH] : I_REQ_A[P_WIDTH-1:0];
                        O_ALU_B      <= sel ? I_REQ_B[2*P_WIDTH-1:P_WIDTH] : I_REQ_B[P_WIDTH-1:0];
                        O_BUSY       <= 1'b1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU output has had a full cycle to settle on stable operands
                    O_RSP_C      <= I_ALU_C;
                    O_RSP_STATUS <= I_ALU_STATUS;
                    O_PSR        <= I_ALU_STATUS;
                    ptr          <= ~owner;
                    O_RSP_VALID  <= owner ? 2'b10 : 2'b01;
                    state        <= RESP;
                end
                RESP: begin
                    if (I_RSP_READY[owner]) begin
                        O_RSP_VALID <= 2'b00;
                        O_BUSY      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    O_RSP_VALID <= 2'b00;
                    O_BUSY      <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a reference ALU model drives the shared ALU port and
// expected responses are queued at stimulus time, then checked on each response handshake.
module tb_alu_arbiter;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic        owner;
        logic [15:0] c;
        logic [4:0]  st;
    } exp_t;

    logic            I_CLK;
    logic            I_RESET;
    logic [1:0]      I_REQ_VALID;
    logic [1:0]      O_REQ_READY;
    logic [7:0]      I_REQ_OPCODE;
    logic [2*W-1:0]  I_REQ_A;
    logic [2*W-1:0]  I_REQ_B;
    logic [1:0]      O_RSP_VALID;
    logic [1:0]      I_RSP_READY;
    logic [W-1:0]    O_RSP_C;
    logic [4:0]      O_RSP_STATUS;
    logic [3:0]      O_ALU_OPCODE;
    logic [W-1:0]    O_ALU_A;
    logic [W-1:0]    O_ALU_B;
    logic [W-1:0]    I_ALU_C;
    logic [4:0]      I_ALU_STATUS;
    logic [4:0]      O_PSR;
    logic            O_BUSY;

    int   cmp_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];
    logic [1:0] last_hs;

    alu_arbiter #(.P_WIDTH(W)) dut (
        .I_CLK(I_CLK), .I_RESET(I_RESET),
        .I_REQ_VALID(I_REQ_VALID), .O_REQ_READY(O_REQ_READY),
        .I_REQ_OPCODE(I_REQ_OPCODE), .I_REQ_A(I_REQ_A), .I_REQ_B(I_REQ_B),
        .O_RSP_VALID(O_RSP_VALID), .I_RSP_READY(I_RSP_READY),
        .O_RSP_C(O_RSP_C), .O_RSP_STATUS(O_RSP_STATUS),
        .O_ALU_OPCODE(O_ALU_OPCODE), .O_ALU_A(O_ALU_A), .O_ALU_B(O_ALU_B),
        .I_ALU_C(I_ALU_C), .I_ALU_STATUS(I_ALU_STATUS),
        .O_PSR(O_PSR), .O_BUSY(O_BUSY)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    // Reference ALU, status = {negative, zero, flag, low, carry}
    function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] c;
        logic [4:0]  st;
        c  = '0;
        st = '0;
        s  = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; c = s[15:0]; st[0] = s[16]; end
            4'd1: begin c = b - a; st[0] = (a > b); st[1] = (b < a); st[4] = c[15]; end
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = a ^ b;
            default: begin c = '0; st = '0; end
        endcase
        return {st, c};
    endfunction

    always_comb {I_ALU_STATUS, I_ALU_C} = alu_model(O_ALU_OPCODE, O_ALU_A, O_ALU_B);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Evaluate handshakes that will fire at the next rising edge, then advance one cycle
    task automatic step();
        exp_t e;
        #1;
        last_hs = I_REQ_VALID & O_REQ_READY;
        if ((O_RSP_VALID & I_RSP_READY) != 2'b00) begin
            if (sb.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $error("FAIL rsp_unexpected: observed rsp_valid 0x%0h expected none", O_RSP_VALID);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(O_RSP_VALID), e.owner ? 32'h2 : 32'h1);
                chk("rsp_c", 32'(O_RSP_C), 32'(e.c));
                chk("rsp_status", 32'(O_RSP_STATUS), 32'(e.st));
                chk("rsp_psr", 32'(O_PSR), 32'(e.st));
            end
        end
        @(negedge I_CLK);
    endtask

    task automatic do_reset();
        I_RESET     = 1'b1;
        I_REQ_VALID = 2'b00;
        step();
        step();
        I_RESET = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            #1;
            if (sb.size() == 0 && !O_BUSY) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic push(input logic owner, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b);
        logic [20:0] r;
        r = alu_model(op, a, b);
        sb.push_back('{owner: owner, c: r[15:0], st: r[20:16]});
    endtask

    logic [3:0]  t3_op [2][3];
    logic [15:0] t3_a  [2][3];
    logic [15:0] t3_b  [2][3];

    initial begin
        I_RESET      = 1'b1;
        I_REQ_VALID  = 2'b00;
        I_REQ_OPCODE = '0;
        I_REQ_A      = '0;
        I_REQ_B      = '0;
        I_RSP_READY  = 2'b11;
        last_hs      = 2'b00;
        @(negedge I_CLK);
        do_reset();

        // Reset state
        #1;
        chk("rst_rsp_valid", 32'(O_RSP_VALID), 32'h0);
        chk("rst_busy", 32'(O_BUSY), 32'h0);
        chk("rst_psr", 32'(O_PSR), 32'h0);
        chk("rst_rsp_c", 32'(O_RSP_C), 32'h0);
        chk("rst_req_ready", 32'(O_REQ_READY), 32'h0);

        // 1: single ADD from requester 0, latency check
        I_REQ_OPCODE = 8'h00;
        I_REQ_A      = {16'h0, 16'h0003};
        I_REQ_B      = {16'h0, 16'h0004};
        I_REQ_VALID  = 2'b01;
        sb.push_back('{owner: 1'b0, c: 16'h0007, st: 5'b00000});
        #1;
        chk("t1_req_ready", 32'(O_REQ_READY), 32'h1);
        step();
        chk("t1_handshake", 32'(last_hs), 32'h1);
        I_REQ_VALID = 2'b00;
        #1;
        chk("t1_exec_rsp_valid", 32'(O_RSP_VALID), 32'h0);
        chk("t1_exec_busy", 32'(O_BUSY), 32'h1);
        chk("t1_exec_opcode", 32'(O_ALU_OPCODE), 32'h0);
        step();
        chk("t1_resp_latency", 32'(O_RSP_VALID), 32'h1);
        wait_idle("t1_done", 10);
        chk("t1_psr", 32'(O_PSR), 32'h0);

        // 2: contested start after reset, requester 0 wins first
        do_reset();
        I_REQ_OPCODE = {4'd1, 4'd2};
        I_REQ_A      = {16'd5, 16'h00FF};
        I_REQ_B      = {16'd3, 16'h0F0F};
        I_REQ_VALID  = 2'b11;
        sb.push_back('{owner: 1'b0, c: 16'h000F, st: 5'b00000});
        sb.push_back('{owner: 1'b1, c: 16'hFFFE, st: 5'b10011});
        for (int n = 0; n < 40; n++) begin
            #1;
            if (I_REQ_VALID == 2'b00 && sb.size() == 0 && !O_BUSY) break;
            step();
            I_REQ_VALID = I_REQ_VALID & ~last_hs;
        end
        chk("t2_done", 32'(sb.size()), 32'd0);

        // 3: both held valid for six ops, grants must alternate starting at 0
        t3_op[0][0] = 4'd0; t3_a[0][0] = 16'h0001; t3_b[0][0] = 16'h0002;
        t3_op[0][1] = 4'd2; t3_a[0][1] = 16'hF0F0; t3_b[0][1] = 16'hFF00;
        t3_op[0][2] = 4'd0; t3_a[0][2] = 16'hFFFF; t3_b[0][2] = 16'h0001;
        t3_op[1][0] = 4'd1; t3_a[1][0] = 16'h0001; t3_b[1][0] = 16'h000A;
        t3_op[1][1] = 4'd3; t3_a[1][1] = 16'h0F00; t3_b[1][1] = 16'h00F0;
        t3_op[1][2] = 4'd1; t3_a[1][2] = 16'h0020; t3_b[1][2] = 16'h0010;
        for (int k = 0; k < 6; k++)
            push(1'(k % 2), t3_op[k % 2][k / 2], t3_a[k % 2][k / 2], t3_b[k % 2][k / 2]);
        begin
            int c0;
            int c1;
            int k;
            c0 = 0;
            c1 = 0;
            k  = 0;
            for (int cyc = 0; cyc < 80; cyc++) begin
                #1;
                if (c0 == 3 && c1 == 3 && sb.size() == 0 && !O_BUSY) break;
                I_REQ_VALID = {1'(c1 < 3), 1'(c0 < 3)};
                if (c0 < 3) begin
                    I_REQ_OPCODE[3:0] = t3_op[0][c0];
                    I_REQ_A[15:0]     = t3_a[0][c0];
                    I_REQ_B[15:0]     = t3_b[0][c0];
                end
                if (c1 < 3) begin
                    I_REQ_OPCODE[7:4] = t3_op[1][c1];
                    I_REQ_A[31:16]    = t3_a[1][c1];
                    I_REQ_B[31:16]    = t3_b[1][c1];
                end
                step();
                if (last_hs != 2'b00) begin
                    chk("t3_grant_order", 32'(last_hs[1]), 32'(k % 2));
                    k++;
                    if (last_hs[0]) c0++;
                    else            c1++;
                end
            end
            I_REQ_VALID = 2'b00;
            chk("t3_ops_granted", 32'(k), 32'd6);
            chk("t3_done", 32'(sb.size()), 32'd0);
        end

        // 4: response back-pressure with non-owner ready and pending request ignored
        I_REQ_OPCODE = 8'h00;
        I_REQ_A      = {16'h0, 16'hFFFF};
        I_REQ_B      = {16'h0, 16'h1235};
        I_REQ_VALID  = 2'b01;
        I_RSP_READY  = 2'b00;
        push(1'b0, 4'd0, 16'hFFFF, 16'h1235);
        step();
        chk("t4_handshake", 32'(last_hs), 32'h1);
        I_REQ_VALID = 2'b00;
        step();
        I_REQ_VALID = 2'b10;
        I_RSP_READY = 2'b10;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("t4_stall_rsp_valid", 32'(O_RSP_VALID), 32'h1);
            chk("t4_stall_rsp_c", 32'(O_RSP_C), 32'h1234);
            chk("t4_stall_req_ready", 32'(O_REQ_READY), 32'h0);
            chk("t4_stall_busy", 32'(O_BUSY), 32'h1);
            step();
        end
        chk("t4_not_consumed", 32'(sb.size()), 32'd1);
        I_REQ_VALID = 2'b00;
        I_RSP_READY = 2'b11;
        wait_idle("t4_done", 10);
        chk("t4_psr", 32'(O_PSR), 32'h01);

        // 5: reset while an op is in EXEC discards it
        I_REQ_OPCODE = 8'h00;
        I_REQ_A      = {16'h0, 16'h0005};
        I_REQ_B      = {16'h0, 16'h0006};
        I_REQ_VALID  = 2'b01;
        step();
        chk("t5_handshake", 32'(last_hs), 32'h1);
        I_REQ_VALID = 2'b00;
        #1;
        chk("t5_in_exec", 32'(O_BUSY), 32'h1);
        I_RESET = 1'b1;
        step();
        I_RESET = 1'b0;
        #1;
        chk("t5_rsp_valid", 32'(O_RSP_VALID), 32'h0);
        chk("t5_busy", 32'(O_BUSY), 32'h0);
        chk("t5_psr", 32'(O_PSR), 32'h0);
        chk("t5_rsp_c", 32'(O_RSP_C), 32'h0);
        chk("t5_rsp_status", 32'(O_RSP_STATUS), 32'h0);
        chk("t5_alu_a", 32'(O_ALU_A), 32'h0);
        chk("t5_alu_b", 32'(O_ALU_B), 32'h0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("t5_no_rsp", 32'(O_RSP_VALID), 32'h0);
        end

        // 6: reserved opcode passes through, result and status zero
        I_REQ_OPCODE = 8'h0F;
        I_REQ_A      = {16'h0, 16'h1234};
        I_REQ_B      = {16'h0, 16'h5678};
        I_REQ_VALID  = 2'b01;
        sb.push_back('{owner: 1'b0, c: 16'h0000, st: 5'b00000});
        step();
        I_REQ_VALID = 2'b00;
        #1;
        chk("t6_alu_opcode", 32'(O_ALU_OPCODE), 32'hF);
        wait_idle("t6_done", 10);
        step();
        chk("t6_alu_a_held", 32'(O_ALU_A), 32'h1234);
        chk("t6_alu_b_held", 32'(O_ALU_B), 32'h5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
